// File: rtl/pcn_pkg.sv
// rtl/pcn_pkg.sv - shared types and constants for the next-PC predictor
package pcn_pkg;

    typedef enum logic [2:0] {
        SI_BR   = 3'd0,
        SI_JAL  = 3'd1,
        SI_JALR = 3'd2
    } specinst_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_detail_e;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Per-entry state that must be clearable by reset; tag/target live in plain arrays.
    typedef struct packed {
        logic      valid;
        specinst_e kind;
        logic [1:0] cnt;
    } btb_entry_t;

    // Saturating 2-bit counter step.
    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic up);
        if (up) return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        else    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/pcn_resolve.sv
// rtl/pcn_resolve.sv - combinational actual-next-PC and branch outcome
module pcn_resolve
    import pcn_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            specinst,
    input  logic [2:0]            detail,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] imme,
    input  logic [DATA_WIDTH-1:0] aluout,
    output logic                  is_ctrl,
    output logic                  taken,
    output logic [DATA_WIDTH-1:0] target,
    output logic [DATA_WIDTH-1:0] actual_pc
);

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] jalr_tgt;

    assign pc_plus4 = pc + DATA_WIDTH'(4);
    assign jalr_tgt = (rs1 + imme) & ~DATA_WIDTH'(1);

    // Branch condition from the ALU result, then the taken target and true successor.
    always_comb begin
        taken     = 1'b0;
        is_ctrl   = 1'b0;
        target    = pc + imme;
        actual_pc = pc_plus4;
        case (detail)
            BR_EQ:          taken = (aluout == '0);
            BR_NE:          taken = (aluout != '0);
            BR_LT, BR_LTU:  taken = (aluout == DATA_WIDTH'(1));
            BR_GE, BR_GEU:  taken = (aluout == '0);
            default:        taken = 1'b0;
        endcase
        case (specinst)
            SI_BR: begin
                is_ctrl   = 1'b1;
                actual_pc = taken ? target : pc_plus4;
            end
            SI_JAL: begin
                is_ctrl   = 1'b1;
                taken     = 1'b1;
                actual_pc = target;
            end
            SI_JALR: begin
                is_ctrl   = 1'b1;
                taken     = 1'b1;
                target    = jalr_tgt;
                actual_pc = jalr_tgt;
            end
            default: begin
                taken     = 1'b0;
                actual_pc = pc_plus4;
            end
        endcase
    end

endmodule

// File: rtl/pcn_predictor.sv
// rtl/pcn_predictor.sv - fetch PC register with BTB/2-bit predictor and EX redirect
module pcn_predictor
    import pcn_pkg::*;
#(
    parameter int                     DATA_WIDTH = 64,
    parameter int                     BTB_DEPTH  = 16,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = 'h8000_0000,
    parameter int                     CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fetch_ready_i,
    output logic                  fetch_valid_o,
    output logic [DATA_WIDTH-1:0] fetch_pc_o,
    output logic [DATA_WIDTH-1:0] fetch_pred_pc_o,
    input  logic                  ex_valid_i,
    input  logic [2:0]            ex_specinst_i,
    input  logic [2:0]            ex_detail_i,
    input  logic [DATA_WIDTH-1:0] ex_pc_i,
    input  logic [DATA_WIDTH-1:0] ex_rs1_i,
    input  logic [DATA_WIDTH-1:0] ex_imme_i,
    input  logic [DATA_WIDTH-1:0] ex_aluout_i,
    input  logic [DATA_WIDTH-1:0] ex_pred_pc_i,
    output logic                  redirect_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic [CNT_W-1:0]      mispredict_cnt_o
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    btb_entry_t            meta_q   [BTB_DEPTH];
    logic [TAG_W-1:0]      tag_q    [BTB_DEPTH];
    logic [DATA_WIDTH-1:0] target_q [BTB_DEPTH];

    logic [DATA_WIDTH-1:0] fetch_pc_q;
    logic                  fetch_valid_q;

    logic [IDX_W-1:0]      lu_idx;
    logic [TAG_W-1:0]      lu_tag;
    btb_entry_t            lu_entry;
    logic                  lu_hit;

    logic                  ex_is_ctrl;
    logic                  ex_taken;
    logic [DATA_WIDTH-1:0] ex_target;
    logic [DATA_WIDTH-1:0] ex_actual;
    logic                  mispredict;
    logic [IDX_W-1:0]      ex_idx;
    logic [TAG_W-1:0]      ex_tag;
    btb_entry_t            ex_entry;
    logic                  ex_hit;
    logic [1:0]            ex_new_cnt;

    assign fetch_pc_o    = fetch_pc_q;
    assign fetch_valid_o = fetch_valid_q;

    pcn_resolve #(.DATA_WIDTH(DATA_WIDTH)) u_resolve (
        .specinst  (ex_specinst_i),
        .detail    (ex_detail_i),
        .pc        (ex_pc_i),
        .rs1       (ex_rs1_i),
        .imme      (ex_imme_i),
        .aluout    (ex_aluout_i),
        .is_ctrl   (ex_is_ctrl),
        .taken     (ex_taken),
        .target    (ex_target),
        .actual_pc (ex_actual)
    );

    assign mispredict = ex_valid_i && (ex_actual != ex_pred_pc_i);

    // Lookup on the current fetch PC; BR entries only redirect when the counter says taken.
    always_comb begin
        lu_idx          = fetch_pc_q[IDX_W+1:2];
        lu_tag          = fetch_pc_q[DATA_WIDTH-1:IDX_W+2];
        lu_entry        = meta_q[lu_idx];
        lu_hit          = lu_entry.valid && (tag_q[lu_idx] == lu_tag);
        fetch_pred_pc_o = fetch_pc_q + DATA_WIDTH'(4);
        if (lu_hit && (lu_entry.kind != SI_BR || lu_entry.cnt[1]))
            fetch_pred_pc_o = target_q[lu_idx];
    end

    // Training-side view of the entry addressed by the resolving instruction.
    always_comb begin
        ex_idx   = ex_pc_i[IDX_W+1:2];
        ex_tag   = ex_pc_i[DATA_WIDTH-1:IDX_W+2];
        ex_entry = meta_q[ex_idx];
        ex_hit   = ex_entry.valid && (tag_q[ex_idx] == ex_tag);
        if (ex_specinst_i != SI_BR)
            ex_new_cnt = CNT_ST;
        else if (ex_hit)
            ex_new_cnt = cnt_step(ex_entry.cnt, ex_taken);
        else
            ex_new_cnt = ex_taken ? CNT_WT : CNT_WNT;
    end

    // Fetch PC, redirect pulse and mispredict statistics; a redirect overrides an advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q       <= RESET_PC;
            fetch_valid_q    <= 1'b0;
            redirect_o       <= 1'b0;
            redirect_pc_o    <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            fetch_valid_q <= 1'b1;
            redirect_o    <= mispredict;
            if (mispredict) begin
                fetch_pc_q    <= ex_actual;
                redirect_pc_o <= ex_actual;
                if (mispredict_cnt_o != '1)
                    mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
            end else if (fetch_valid_q && fetch_ready_i) begin
                fetch_pc_q <= fetch_pred_pc_o;
            end
        end
    end

    // Valid/type/counter table: install or train control ops, drop aliased entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BTB_DEPTH; i++)
                meta_q[i] <= '{valid: 1'b0, kind: SI_BR, cnt: CNT_WNT};
        end else if (ex_valid_i) begin
            if (ex_is_ctrl)
                meta_q[ex_idx] <= '{valid: 1'b1, kind: specinst_e'(ex_specinst_i), cnt: ex_new_cnt};
            else if (ex_hit)
                meta_q[ex_idx].valid <= 1'b0;
        end
    end

    // Tag and target storage; meaningful only while the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        if (ex_valid_i && ex_is_ctrl) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
        end
    end

endmodule

// File: tb/tb_pcn_predictor.sv
// tb/tb_pcn_predictor.sv - directed self-checking bench for pcn_predictor
module tb_pcn_predictor;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_ready_i;
    logic        fetch_valid_o;
    logic [63:0] fetch_pc_o;
    logic [63:0] fetch_pred_pc_o;
    logic        ex_valid_i;
    logic [2:0]  ex_specinst_i;
    logic [2:0]  ex_detail_i;
    logic [63:0] ex_pc_i;
    logic [63:0] ex_rs1_i;
    logic [63:0] ex_imme_i;
    logic [63:0] ex_aluout_i;
    logic [63:0] ex_pred_pc_i;
    logic        redirect_o;
    logic [63:0] redirect_pc_o;
    logic [31:0] mispredict_cnt_o;

    int n_total = 0;
    int n_pass  = 0;

    pcn_predictor #(
        .DATA_WIDTH (64),
        .BTB_DEPTH  (16),
        .RESET_PC   (64'h8000_0000),
        .CNT_W      (32)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .fetch_ready_i    (fetch_ready_i),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_pred_pc_o  (fetch_pred_pc_o),
        .ex_valid_i       (ex_valid_i),
        .ex_specinst_i    (ex_specinst_i),
        .ex_detail_i      (ex_detail_i),
        .ex_pc_i          (ex_pc_i),
        .ex_rs1_i         (ex_rs1_i),
        .ex_imme_i        (ex_imme_i),
        .ex_aluout_i      (ex_aluout_i),
        .ex_pred_pc_i     (ex_pred_pc_i),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic ex_drive(input logic [2:0] si, input logic [2:0] det, input logic [63:0] pc,
                            input logic [63:0] rs1, input logic [63:0] imm,
                            input logic [63:0] alu, input logic [63:0] pred);
        ex_valid_i    = 1'b1;
        ex_specinst_i = si;
        ex_detail_i   = det;
        ex_pc_i       = pc;
        ex_rs1_i      = rs1;
        ex_imme_i     = imm;
        ex_aluout_i   = alu;
        ex_pred_pc_i  = pred;
    endtask

    task automatic ex_idle();
        ex_valid_i    = 1'b0;
        ex_specinst_i = 3'd7;
        ex_detail_i   = 3'd0;
        ex_pc_i       = '0;
        ex_rs1_i      = '0;
        ex_imme_i     = '0;
        ex_aluout_i   = '0;
        ex_pred_pc_i  = '0;
    endtask

    initial begin
        rst_ni        = 1'b0;
        fetch_ready_i = 1'b0;
        ex_idle();
        @(negedge clk_i);
        check("rst_valid",    {63'd0, fetch_valid_o}, 64'd0);
        check("rst_pc",       fetch_pc_o, 64'h8000_0000);
        check("rst_redirect", {63'd0, redirect_o}, 64'd0);
        check("rst_cnt",      {32'd0, mispredict_cnt_o}, 64'd0);

        // Release and stream sequentially.
        rst_ni        = 1'b1;
        fetch_ready_i = 1'b1;
        step();
        check("valid_up",  {63'd0, fetch_valid_o}, 64'd1);
        check("seq_pc0",   fetch_pc_o, 64'h8000_0000);
        step();
        check("seq_pc1",   fetch_pc_o, 64'h8000_0004);
        step();
        check("seq_pc2",   fetch_pc_o, 64'h8000_0008);
        check("seq_pred2", fetch_pred_pc_o, 64'h8000_000C);
        check("seq_redir", {63'd0, redirect_o}, 64'd0);

        // Taken BEQ predicted not taken.
        ex_drive(3'd0, 3'b000, 64'h8000_0010, 64'd0, 64'h20, 64'd0, 64'h8000_0014);
        step();
        ex_idle();
        check("beq_redir",    {63'd0, redirect_o}, 64'd1);
        check("beq_redir_pc", redirect_pc_o, 64'h8000_0030);
        check("beq_fetch_pc", fetch_pc_o, 64'h8000_0030);
        check("beq_cnt",      {32'd0, mispredict_cnt_o}, 64'd1);
        step();
        check("beq_pulse_end", {63'd0, redirect_o}, 64'd0);
        check("beq_pc_hold",   redirect_pc_o, 64'h8000_0030);
        check("beq_advance",   fetch_pc_o, 64'h8000_0034);

        // Refetch the branch through a non-control mispredict; hold fetch.
        fetch_ready_i = 1'b0;
        ex_drive(3'd3, 3'b000, 64'h8000_000C, 64'd0, 64'd0, 64'd0, 64'd0);
        step();
        ex_idle();
        check("refetch_pc",   fetch_pc_o, 64'h8000_0010);
        check("refetch_pred", fetch_pred_pc_o, 64'h8000_0030);
        check("refetch_cnt",  {32'd0, mispredict_cnt_o}, 64'd2);

        // Not taken, correctly carried pc+4: trains 10->01, no redirect.
        ex_drive(3'd0, 3'b000, 64'h8000_0010, 64'd0, 64'h20, 64'd1, 64'h8000_0014);
        step();
        ex_idle();
        check("nt1_redir", {63'd0, redirect_o}, 64'd0);
        check("nt1_pred",  fetch_pred_pc_o, 64'h8000_0014);
        check("nt1_pc",    fetch_pc_o, 64'h8000_0010);

        // Not taken, carried the old taken prediction: redirect to fall-through.
        ex_drive(3'd0, 3'b000, 64'h8000_0010, 64'd0, 64'h20, 64'd1, 64'h8000_0030);
        step();
        ex_idle();
        check("nt2_redir",    {63'd0, redirect_o}, 64'd1);
        check("nt2_redir_pc", redirect_pc_o, 64'h8000_0014);
        check("nt2_cnt",      {32'd0, mispredict_cnt_o}, 64'd3);

        // JALR with odd sum; redirect wins over ready.
        fetch_ready_i = 1'b1;
        ex_drive(3'd2, 3'b000, 64'h8000_0040, 64'h1001, 64'h4, 64'd0, 64'h8000_0044);
        step();
        ex_idle();
        check("jalr_redir_pc", redirect_pc_o, 64'h1004);
        check("jalr_fetch_pc", fetch_pc_o, 64'h1004);
        check("jalr_pred",     fetch_pred_pc_o, 64'h1008);

        // Back-to-back mispredicts: JAL then a non-control op.
        ex_drive(3'd1, 3'b000, 64'h8000_0100, 64'd0, 64'h10, 64'd0, 64'd0);
        step();
        check("b2b_redir0", {63'd0, redirect_o}, 64'd1);
        check("b2b_pc0",    redirect_pc_o, 64'h8000_0110);
        ex_drive(3'd4, 3'b000, 64'h200, 64'd0, 64'd0, 64'd0, 64'd0);
        step();
        check("b2b_redir1", {63'd0, redirect_o}, 64'd1);
        check("b2b_pc1",    redirect_pc_o, 64'h204);
        check("b2b_cnt",    {32'd0, mispredict_cnt_o}, 64'd6);

        // Land on the trained JAL and observe its target prediction.
        fetch_ready_i = 1'b0;
        ex_drive(3'd3, 3'b000, 64'h8000_00FC, 64'd0, 64'd0, 64'd0, 64'd0);
        step();
        ex_idle();
        check("jal_hit_pc",   fetch_pc_o, 64'h8000_0100);
        check("jal_hit_pred", fetch_pred_pc_o, 64'h8000_0110);

        // Asynchronous reset while redirect_o is high.
        rst_ni = 1'b0;
        #1;
        check("arst_redir",    {63'd0, redirect_o}, 64'd0);
        check("arst_redir_pc", redirect_pc_o, 64'd0);
        check("arst_pc",       fetch_pc_o, 64'h8000_0000);
        check("arst_valid",    {63'd0, fetch_valid_o}, 64'd0);
        check("arst_cnt",      {32'd0, mispredict_cnt_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        ex_drive(3'd3, 3'b000, 64'h8000_00FC, 64'd0, 64'd0, 64'd0, 64'd0);
        step();
        ex_idle();
        check("post_rst_pc",   fetch_pc_o, 64'h8000_0100);
        check("post_rst_miss", fetch_pred_pc_o, 64'h8000_0104);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
